// File: rtl/systolic_output_deskew_pkg.sv
// Shared types and width helpers for the systolic output deskew block.
// Optional watchdog is enabled with DESKEW_TIMEOUT_EN (see systolic_output_deskew.sv).
package systolic_out_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_t;

  // Minimum one bit so degenerate sizes still produce legal vectors.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Row counters must be able to hold the value ROWS itself (the "full" marker).
  function automatic int row_cnt_w(input int rows);
    return cnt_w(rows + 1);
  endfunction

  function automatic int col_lsb(input int col, input int word_size);
    return col * word_size;
  endfunction

endpackage

// File: rtl/systolic_output_deskew_if.sv
// Row-beat output stream of the deskew block: valid/ready plus row payload.
interface systolic_output_deskew_if
  import systolic_out_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16
);

  localparam int IDX_W = cnt_w(ROWS);

  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*WORD_SIZE-1:0] out_row_data;
  logic [IDX_W-1:0]          out_row_idx;
  logic                      out_last;

  modport master (
    output out_valid,
    output out_row_data,
    output out_row_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_row_data,
    input  out_row_idx,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/systolic_output_deskew_col_capture.sv
// Per-column capture tracker: de-duplicates held samples and tracks the
// next buffer row for one systolic column.
module deskew_col_capture
  import systolic_out_pkg::*;
#(
  parameter  int ROWS        = 4,
  parameter  int HOLD_CYCLES = 2,
  localparam int RW          = row_cnt_w(ROWS),
  localparam int IW          = cnt_w(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          active,
  input  logic          collect,
  input  logic          col_valid,
  output logic          capture,
  output logic          drop,
  output logic          full_next,
  output logic [IW-1:0] row_idx
);

  localparam int            HW        = cnt_w(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] ROWS_C    = RW'(ROWS);

  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] row_q, row_d;
  logic          qualified;
  logic          full;

  // Only the first clock of each held sample is a candidate for capture.
  always_comb begin
    full      = (row_q == ROWS_C);
    qualified = active && col_valid && (hold_q == '0);
    capture   = qualified && collect && !full;
    drop      = qualified && (!collect || full);

    hold_d = hold_q;
    if (clear || !active || !col_valid) begin
      hold_d = '0;
    end else if (hold_q == HOLD_LAST) begin
      hold_d = '0;
    end else begin
      hold_d = hold_q + 1'b1;
    end

    row_d = row_q;
    if (clear) begin
      row_d = '0;
    end else if (capture) begin
      row_d = row_q + 1'b1;
    end

    full_next = (row_d == ROWS_C);
    row_idx   = row_q[IW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      row_q  <= '0;
    end else begin
      hold_q <= hold_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/systolic_output_deskew.sv
// Collects diagonally skewed systolic column outputs into a ROWS x COLS buffer
// and re-emits them one row per beat. DESKEW_TIMEOUT_EN adds a COLLECT watchdog.
module systolic_output_deskew
  import systolic_out_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int WORD_SIZE      = 16,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [COLS-1:0]           col_valid,
  input  logic [COLS*WORD_SIZE-1:0] bottom_data,
  systolic_output_deskew_if.master  out_if,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
`ifdef DESKEW_TIMEOUT_EN
  ,
  output logic                      timeout
`endif
);

  localparam int               IW       = cnt_w(ROWS);
  localparam logic [IW-1:0]    LAST_IDX = IW'(ROWS - 1);

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [WORD_SIZE-1:0] buf_q [ROWS][COLS];
  logic [WORD_SIZE-1:0] buf_d [ROWS][COLS];

  logic                clear_cols;
  logic                active;
  logic                in_collect;
  logic [COLS-1:0]     cap;
  logic [COLS-1:0]     drop;
  logic [COLS-1:0]     full_next;
  logic [IW-1:0]       cap_row [COLS];

`ifdef DESKEW_TIMEOUT_EN
  localparam int            WD_W     = cnt_w(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
`endif

  assign clear_cols = (state_q == IDLE) && start;
  assign active     = (state_q != IDLE);
  assign in_collect = (state_q == COLLECT);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    deskew_col_capture #(
      .ROWS        (ROWS),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_capture (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_cols),
      .active    (active),
      .collect   (in_collect),
      .col_valid (col_valid[c]),
      .capture   (cap[c]),
      .drop      (drop[c]),
      .full_next (full_next[c]),
      .row_idx   (cap_row[c])
    );
  end

  // Drain entry counts captures landing on the same edge (full_next, not full).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | (|drop);
    buf_d   = buf_q;
`ifdef DESKEW_TIMEOUT_EN
    wd_d    = wd_q;
    to_d    = to_q;
`endif

    for (int c = 0; c < COLS; c++) begin
      if (cap[c]) begin
        buf_d[cap_row[c]][c] = bottom_data[col_lsb(c, WORD_SIZE) +: WORD_SIZE];
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          idx_d   = '0;
          ovf_d   = 1'b0;
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              buf_d[r][c] = '0;
            end
          end
`ifdef DESKEW_TIMEOUT_EN
          wd_d = '0;
          to_d = 1'b0;
`endif
        end
      end
      COLLECT: begin
`ifdef DESKEW_TIMEOUT_EN
        wd_d = (|cap) ? '0 : wd_q + 1'b1;
`endif
        if (&full_next) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
`ifdef DESKEW_TIMEOUT_EN
        else if (wd_d == WD_LIMIT) begin
          state_d = DRAIN;
          idx_d   = '0;
          to_d    = 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (out_if.out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DESKEW_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
`ifdef DESKEW_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  // The buffer is fully rewritten on every start, so it needs no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  // Row data is masked outside DRAIN so idle outputs read as zero.
  always_comb begin
    out_if.out_row_data = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        out_if.out_row_data[col_lsb(c, WORD_SIZE) +: WORD_SIZE] = buf_q[idx_q][c];
      end
    end
  end

  assign out_if.out_valid   = (state_q == DRAIN);
  assign out_if.out_row_idx = idx_q;
  assign out_if.out_last    = (state_q == DRAIN) && (idx_q == LAST_IDX);
  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign overflow           = ovf_q;
`ifdef DESKEW_TIMEOUT_EN
  assign timeout            = to_q;
`endif

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed, table-driven bench for systolic_output_deskew (2x2 array):
// instance a uses HOLD_CYCLES=2, instance b uses HOLD_CYCLES=1.
module tb_systolic_output_deskew;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  col_valid;
  logic [31:0] bottom_data;
  logic        out_ready;

  logic busy_a, done_a, ovf_a, to_a;
  logic busy_b, done_b, ovf_b, to_b;

  int n_cmp  = 0;
  int n_fail = 0;

  systolic_output_deskew_if #(.ROWS(2), .COLS(2), .WORD_SIZE(16)) if_a ();
  systolic_output_deskew_if #(.ROWS(2), .COLS(2), .WORD_SIZE(16)) if_b ();

  assign if_a.out_ready = out_ready;
  assign if_b.out_ready = out_ready;

  systolic_output_deskew #(
    .ROWS(2), .COLS(2), .WORD_SIZE(16), .HOLD_CYCLES(2), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .col_valid   (col_valid),
    .bottom_data (bottom_data),
    .out_if      (if_a.master),
    .busy        (busy_a),
    .done        (done_a),
`ifdef DESKEW_TIMEOUT_EN
    .timeout     (to_a),
`endif
    .overflow    (ovf_a)
  );

  systolic_output_deskew #(
    .ROWS(2), .COLS(2), .WORD_SIZE(16), .HOLD_CYCLES(1), .TIMEOUT_CYCLES(8)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .col_valid   (col_valid),
    .bottom_data (bottom_data),
    .out_if      (if_b.master),
    .busy        (busy_b),
    .done        (done_b),
`ifdef DESKEW_TIMEOUT_EN
    .timeout     (to_b),
`endif
    .overflow    (ovf_b)
  );

`ifndef DESKEW_TIMEOUT_EN
  assign to_a = 1'b0;
  assign to_b = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [1:0]  cv;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        rdy;
    logic        e_busy;
    logic        e_valid;
    logic        e_idx;
    logic        e_last;
    logic [31:0] e_data;
    logic        e_done;
    logic        e_ovf;
    logic        e_to;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] ROW0 = 32'h0012_0011;
  localparam logic [31:0] ROW1 = 32'h0022_0021;

  function automatic vec_t mk(input bit st, input bit [1:0] cv, input bit [15:0] d0,
                              input bit [15:0] d1, input bit rdy, input bit busy,
                              input bit valid, input bit idx, input bit last,
                              input bit [31:0] data, input bit done, input bit ovf);
    vec_t v;
    v.start = st;   v.cv = cv;   v.d0 = d0;   v.d1 = d1;   v.rdy = rdy;
    v.e_busy = busy; v.e_valid = valid; v.e_idx = idx; v.e_last = last;
    v.e_data = data; v.e_done = done; v.e_ovf = ovf; v.e_to = 1'b0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    start       = v.start;
    col_valid   = v.cv;
    bottom_data = {v.d1, v.d0};
    out_ready   = v.rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic checkVec(input string tag, input vec_t v, input bit use_b);
    checkOutput({tag, ".busy"},  use_b ? 32'(busy_b) : 32'(busy_a), 32'(v.e_busy));
    checkOutput({tag, ".valid"}, use_b ? 32'(if_b.out_valid) : 32'(if_a.out_valid), 32'(v.e_valid));
    checkOutput({tag, ".idx"},   use_b ? 32'(if_b.out_row_idx) : 32'(if_a.out_row_idx), 32'(v.e_idx));
    checkOutput({tag, ".last"},  use_b ? 32'(if_b.out_last) : 32'(if_a.out_last), 32'(v.e_last));
    checkOutput({tag, ".data"},  use_b ? if_b.out_row_data : if_a.out_row_data, v.e_data);
    checkOutput({tag, ".done"},  use_b ? 32'(done_b) : 32'(done_a), 32'(v.e_done));
    checkOutput({tag, ".ovf"},   use_b ? 32'(ovf_b) : 32'(ovf_a), 32'(v.e_ovf));
`ifdef DESKEW_TIMEOUT_EN
    checkOutput({tag, ".timeout"}, use_b ? 32'(to_b) : 32'(to_a), 32'(v.e_to));
`endif
  endtask

  task automatic runVectors(input string name, input bit use_b);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVec($sformatf("%s[%0d]", name, i), vecs[i], use_b);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    start = 1'b0; col_valid = '0; bottom_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Shared opening of the basic skewed collection: col0 first, col1 two clocks later.
  task automatic pushSkewPrefix();
    vecs.push_back(mk(1, 2'b00, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 16'h0011, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 16'h0011, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 16'h0021, 16'h0012, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 16'h0021, 16'h0012, 0, 1, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic loadBasic();
    vecs.delete();
    pushSkewPrefix();
    vecs.push_back(mk(0, 2'b10, 16'h0000, 16'h0022, 1, 1, 1, 0, 0, ROW0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 16'h0000, 16'h0022, 1, 1, 1, 1, 1, ROW1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    vec_t v;
    $display("[TB] start");
    doReset();
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVec("reset_a", v, 1'b0);
    checkVec("reset_b", v, 1'b1);

    loadBasic();
    runVectors("basic", 1'b0);

    // Consumer stalls for three clocks while row 0 is presented.
    vecs.delete();
    pushSkewPrefix();
    vecs.push_back(mk(0, 2'b10, 16'h0000, 16'h0022, 0, 1, 1, 0, 0, ROW0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 16'h0000, 16'h0022, 0, 1, 1, 0, 0, ROW0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 0, 1, 1, 0, 0, ROW0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 0, 1, 1, 0, 0, ROW0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 1, 1, 1, 1, 1, ROW1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0));
    runVectors("stall", 1'b0);

    // Extra col0 sample after col0 is full: dropped, overflow sticky until next start.
    vecs.delete();
    vecs.push_back(mk(1, 2'b00, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 16'h0011, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 16'h0011, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 16'h0021, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 16'h0021, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 16'h0000, 16'h0012, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 16'h0099, 16'h0012, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 2'b11, 16'h0099, 16'h0022, 0, 1, 1, 0, 0, ROW0, 0, 1));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 1, 1, 1, 1, 1, ROW1, 0, 1));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 2'b00, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    runVectors("overflow", 1'b0);

    // Reset after one capture aborts without a done pulse; a fresh run then works.
    vecs.delete();
    vecs.push_back(mk(0, 2'b01, 16'h0055, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    runVectors("pre_rst", 1'b0);
    rst = 1'b1;
    vecs.delete();
    vecs.push_back(mk(0, 2'b01, 16'h0066, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0));
    runVectors("mid_rst", 1'b0);
    rst = 1'b0;
    vecs.delete();
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0));
    runVectors("post_rst", 1'b0);
    loadBasic();
    runVectors("after_rst", 1'b0);

    // HOLD_CYCLES=1 instance: both columns captured on two consecutive clocks.
    doReset();
    vecs.delete();
    vecs.push_back(mk(1, 2'b00, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 16'h0A01, 16'h0B01, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 16'h0A02, 16'h0B02, 0, 1, 1, 0, 0, 32'h0B01_0A01, 0, 0));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 1, 1, 1, 1, 1, 32'h0B02_0A02, 0, 0));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 1, 0));
    runVectors("hold1", 1'b1);

    // Only col0 delivers; with the watchdog the block drains after 8 idle clocks.
    doReset();
    vecs.delete();
    vecs.push_back(mk(1, 2'b00, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 16'h0011, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 16'h0021, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) begin
      vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    end
`ifdef DESKEW_TIMEOUT_EN
    v = mk(0, 2'b00, 16'h0000, 16'h0000, 0, 1, 1, 0, 0, 32'h0000_0011, 0, 0);
    v.e_to = 1'b1;
    vecs.push_back(v);
    v = mk(0, 2'b00, 16'h0000, 16'h0000, 1, 1, 1, 1, 1, 32'h0000_0021, 0, 0);
    v.e_to = 1'b1;
    vecs.push_back(v);
    v = mk(0, 2'b00, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 1, 0);
    v.e_to = 1'b1;
    vecs.push_back(v);
    vecs.push_back(mk(1, 2'b00, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
`else
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(0, 2'b00, 16'h0000, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 0));
    end
`endif
    runVectors("col0_only", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_output_deskew.md
Name: systolic_output_deskew

Overview:
- Downstream consumer of the systolic matmul control FSM's outputs (`bottom_out` data and per-column output-valid flags).
- Weight-stationary outputs arrive diagonally skewed: column c starts one output slot after column c-1, and each column emits ROWS results.
- This block captures each column's stream into a ROWS x COLS result buffer and re-emits the matrix one row per beat over a valid/ready interface.
- It sits between the systolic array bottom edge and the result writeback/compare logic.

Parameters:
- ROWS, 4, systolic rows; result rows per column.
- COLS, 4, systolic columns.
- WORD_SIZE, 16, bits per result element.
- HOLD_CYCLES, 2, clocks each output is held on `bottom_data` (1 matmul cycle = 2 clk); must be ≥1.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with DESKEW_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a new collection; honoured only in IDLE.
- col_valid  in  COLS  bit c = `bottom_data` column c valid this clock.
- bottom_data  in  COLS*WORD_SIZE  column c at [c*WORD_SIZE +: WORD_SIZE].
- busy  out  1  high in COLLECT or DRAIN.
- out_valid  out  1  row beat available.
- out_ready  in  1  consumer accepts beat.
- out_row_data  out  COLS*WORD_SIZE  result row out_row_idx, same column packing as bottom_data.
- out_row_idx  out  $clog2(ROWS)  row index of the current beat.
- out_last  out  1  high with the beat for row ROWS-1.
- done  out  1  one-clock pulse after the last beat is accepted.
- overflow  out  1  sticky; a sample was dropped.
- timeout  out  1  sticky; present only with DESKEW_TIMEOUT_EN.

Behaviour:
- Reset:
  - state=IDLE; all outputs, counters and flags are 0.
  - Buffer contents are don't-care.
  - rst mid-operation aborts immediately; no done pulse.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - start=1 moves to COLLECT next clock.
  - The same edge zeroes the buffer, row counters, hold counters, overflow and timeout.
  - col_valid is ignored in IDLE.
- Per-column capture (COLLECT only):
  - hold_cnt[c] counts 0..HOLD_CYCLES-1 and wraps while col_valid[c]=1. It clears to 0 on any clock with col_valid[c]=0.
  - A sample is captured when col_valid[c]=1, hold_cnt[c]==0 and row_cnt[c]<ROWS: buf[row_cnt[c]][c] ← bottom_data column c, then row_cnt[c]++.
  - If the capture condition holds but row_cnt[c]==ROWS, the sample is dropped and overflow=1.
  - Columns are independent; simultaneous captures in several columns in one clock are required.
- COLLECT→DRAIN:
  - Triggered on the clock edge where every row_cnt[c] reaches ROWS, counting captures made on that edge.
  - out_valid=1 and out_row_idx=0 on the following cycle, i.e. 1 clk after the final capture.
- DRAIN:
  - out_row_data = buf[out_row_idx].
  - out_valid stays 1 and data/idx stay stable until out_valid&&out_ready.
  - On handshake, out_row_idx increments.
  - A handshake with out_row_idx==ROWS-1 (out_last=1) returns to IDLE. out_valid drops and done=1 for exactly that next clock.
  - A new start is accepted on the clock following done.
- In DRAIN, any capture-qualified col_valid sets overflow; data is dropped and the buffer is unchanged.
- start in COLLECT or DRAIN is ignored.
- out_ready is ignored outside DRAIN.

Optional Feature:
- DESKEW_TIMEOUT_EN defined:
  - A watchdog counter runs in COLLECT. It clears on start and on any capture, and increments otherwise.
  - On reaching TIMEOUT_CYCLES, timeout=1 (sticky until next start) and the block goes to DRAIN.
  - Uncaptured entries drain as 0.
- Not defined: no counter and no timeout port; COLLECT waits indefinitely.

Decomposition:
- Package systolic_out_pkg holds:
  - the state enum {IDLE, COLLECT, DRAIN};
  - localparam-width helpers for row/hold counter widths;
  - the column slice macro/function for WORD_SIZE packing.
- Sub-module deskew_col_capture holds the per-column hold_cnt, row_cnt, capture strobe and full flag. The top instantiates it COLS times via generate, and the buffer write uses its strobe/row index.

Test Plan:
- ROWS=COLS=2, HOLD=2; start, then col0 valid 4 clk with data 0x11 then 0x21, col1 valid 2 clk later with 0x12 then 0x22; out_ready=1 → beats row0={0x12,0x11}, row1={0x22,0x21}; out_last on row1; done pulses once.
- Same stimulus with out_ready low for 3 clk on row0 → out_valid, out_row_data and out_row_idx stable for those clocks; no lost or duplicated beat.
- Extra col0 valid run (0x99) after col0 full → overflow=1, buffer row values unchanged, drain still correct.
- rst asserted mid-COLLECT after 1 capture → all outputs 0, state IDLE; a fresh start then collects a full matrix correctly.
- HOLD=1, all columns valid simultaneously for 2 clk → capture every clock; DRAIN begins 1 clk after the second capture.
- With DESKEW_TIMEOUT_EN and TIMEOUT_CYCLES=8: only col0 delivers → timeout=1 after 8 idle clk; drained rows show column 1 = 0.
